// File: rtl/fft_pkg.sv
// Shared FFT datapath types and helpers: complex sample type, ceil-log2, default width.
package fft_pkg;

  localparam int FFT_DATA_WIDTH_DEF = 16;

  typedef struct packed {
    logic signed [FFT_DATA_WIDTH_DEF-1:0] re;
    logic signed [FFT_DATA_WIDTH_DEF-1:0] im;
  } cplx_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_r2sdf_stage_bfly.sv
// Butterfly_Radix2: combinational radix-2 butterfly, sum and difference wrap to DataWidth.
module Butterfly_Radix2 #(
  parameter int DataWidth = 16
) (
  input  logic signed [DataWidth-1:0] a_re,
  input  logic signed [DataWidth-1:0] a_im,
  input  logic signed [DataWidth-1:0] b_re,
  input  logic signed [DataWidth-1:0] b_im,
  output logic signed [DataWidth-1:0] sum_re,
  output logic signed [DataWidth-1:0] sum_im,
  output logic signed [DataWidth-1:0] diff_re,
  output logic signed [DataWidth-1:0] diff_im
);

  assign sum_re  = a_re + b_re;
  assign sum_im  = a_im + b_im;
  assign diff_re = a_re - b_re;
  assign diff_im = a_im - b_im;

endmodule

// File: rtl/fft_r2sdf_stage.sv
// Radix-2 DIF single-path delay-feedback FFT stage wrapping Butterfly_Radix2.
// Optional macro FFT_STAGE_SCALE_EN: halve butterfly operands (floor) for per-stage 1/2 scaling.
module fft_r2sdf_stage
  import fft_pkg::*;
#(
  parameter int DataWidth = FFT_DATA_WIDTH_DEF,
  parameter int Depth     = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic signed [DataWidth-1:0] in_re,
  input  logic signed [DataWidth-1:0] in_im,
  input  logic                        flush,
  output logic                        out_valid,
  output logic signed [DataWidth-1:0] out_re,
  output logic signed [DataWidth-1:0] out_im,
  output logic                        out_is_diff
);

  localparam int AW = clog2(Depth);

  typedef struct packed {
    logic signed [DataWidth-1:0] re;
    logic signed [DataWidth-1:0] im;
  } cplx_w_t;

  logic [AW:0]   cnt;
  logic          primed;
  cplx_w_t       dl [Depth];

  logic          adv;
  logic          phase;
  logic          emit;
  logic [AW-1:0] addr;
  cplx_w_t       sample;
  cplx_w_t       head;
  cplx_w_t       x0;
  cplx_w_t       x1;
  cplx_w_t       y0;
  cplx_w_t       y1;

  assign adv       = in_valid | flush;
  assign phase     = cnt[AW];
  assign addr      = cnt[AW-1:0];
  assign emit      = adv & (phase | primed);
  assign sample.re = in_valid ? in_re : '0;
  assign sample.im = in_valid ? in_im : '0;
  assign head      = dl[addr];

`ifdef FFT_STAGE_SCALE_EN
  assign x0.re = head.re >>> 1;
  assign x0.im = head.im >>> 1;
  assign x1.re = sample.re >>> 1;
  assign x1.im = sample.im >>> 1;
`else
  assign x0 = head;
  assign x1 = sample;
`endif

  Butterfly_Radix2 #(.DataWidth(DataWidth)) u_bfly (
    .a_re    (x0.re),
    .a_im    (x0.im),
    .b_re    (x1.re),
    .b_im    (x1.im),
    .sum_re  (y0.re),
    .sum_im  (y0.im),
    .diff_re (y1.re),
    .diff_im (y1.im)
  );

  // Delay line needs no reset: primed keeps stale entries from ever reaching the output.
  always_ff @(posedge clk) begin
    if (adv) dl[addr] <= phase ? y1 : sample;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      primed      <= 1'b0;
      out_valid   <= 1'b0;
      out_re      <= '0;
      out_im      <= '0;
      out_is_diff <= 1'b0;
    end else begin
      out_valid <= emit;
      if (adv) begin
        cnt <= cnt + 1'b1;
        if (phase) primed <= 1'b1;
      end
      if (emit) begin
        out_re      <= phase ? y0.re : head.re;
        out_im      <= phase ? y0.im : head.im;
        out_is_diff <= ~phase;
      end
    end
  end

endmodule

// File: tb/tb_fft_r2sdf_stage.sv
// Self-checking bench for fft_r2sdf_stage (Depth=4, DataWidth=16) against a frame-level model.
module tb_fft_r2sdf_stage;
  import fft_pkg::*;

  localparam int D  = 4;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] in_re = '0;
  logic signed [DW-1:0] in_im = '0;
  logic                 flush = 1'b0;
  logic                 out_valid;
  logic signed [DW-1:0] out_re;
  logic signed [DW-1:0] out_im;
  logic                 out_is_diff;

  fft_r2sdf_stage #(.DataWidth(DW), .Depth(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_re       (in_re),
    .in_im       (in_im),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_re      (out_re),
    .out_im      (out_im),
    .out_is_diff (out_is_diff)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Frame-level model: current frame's first half, pending differences of the previous frame.
  int    k = 0;
  bit    pend_ok = 1'b0;
  cplx_t fr [D];
  cplx_t pd [D];

  int ld_re[$];
  int ld_d[$];
  int lm_re[$];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] sc(input logic signed [DW-1:0] x);
`ifdef FFT_STAGE_SCALE_EN
    return x >>> 1;
`else
    return x;
`endif
  endfunction

  task automatic model_reset();
    k = 0;
    pend_ok = 1'b0;
  endtask

  // One clock cycle: drive inputs, derive the expected output, check it after the edge.
  task automatic step(input bit v, input bit f, input int r, input int im);
    cplx_t s, e;
    logic signed [DW-1:0] a, b;
    bit ev, ed;
    in_valid = v;
    flush    = f;
    in_re    = DW'(r);
    in_im    = DW'(im);
    s.re = v ? DW'(r) : '0;
    s.im = v ? DW'(im) : '0;
    ev = 1'b0;
    ed = 1'b0;
    e  = '0;
    if (v || f) begin
      if (k < D) begin
        if (pend_ok) begin
          ev = 1'b1;
          ed = 1'b1;
          e  = pd[k];
        end
        fr[k] = s;
      end else begin
        a = sc(fr[k-D].re); b = sc(s.re);
        e.re = a + b;  pd[k-D].re = a - b;
        a = sc(fr[k-D].im); b = sc(s.im);
        e.im = a + b;  pd[k-D].im = a - b;
        ev = 1'b1;
        pend_ok = 1'b1;
      end
      k = (k + 1) % (2 * D);
    end
    @(posedge clk);
    #1;
    chk("out_valid", int'(out_valid), int'(ev));
    if (ev) begin
      chk("out_re", int'(out_re), int'(e.re));
      chk("out_im", int'(out_im), int'(e.im));
      chk("out_is_diff", int'(out_is_diff), int'(ed));
      lm_re.push_back(int'(e.re));
    end
    if (out_valid) begin
      ld_re.push_back(int'(out_re));
      ld_d.push_back(int'(out_is_diff));
    end
  endtask

  task automatic clear_logs();
    ld_re.delete();
    ld_d.delete();
    lm_re.delete();
  endtask

  task automatic check_log(input string name, input int first, input int exp_re[$], input int exp_d[$]);
    for (int i = 0; i < exp_re.size(); i++) begin
      if (first + i >= ld_re.size() || first + i >= lm_re.size()) begin
        chk({name, "_missing"}, ld_re.size(), first + i + 1);
      end else begin
        chk({name, "_re"}, ld_re[first+i], exp_re[i]);
        chk({name, "_model"}, lm_re[first+i], exp_re[i]);
        chk({name, "_flag"}, ld_d[first+i], exp_d[i]);
      end
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_re", int'(out_re), 0);
    chk("rst_out_im", int'(out_im), 0);
    chk("rst_out_is_diff", int'(out_is_diff), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int base);
    for (int i = 0; i < 2 * D; i++) step(1'b1, 1'b0, base + i, 0);
  endtask

  task automatic flushes(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 0, 0);
  endtask

  initial begin
    int q_re[$];
    int q_d[$];
    @(posedge clk);
    #1;
    do_reset();

    // Single frame 1..8 drained by flush
    clear_logs();
    frame(1);
    flushes(4);
`ifdef FFT_STAGE_SCALE_EN
    q_re = '{2, 4, 4, 6, -2, -2, -2, -2};
`else
    q_re = '{6, 8, 10, 12, -4, -4, -4, -4};
`endif
    q_d = '{0, 0, 0, 0, 1, 1, 1, 1};
    check_log("frame1", 0, q_re, q_d);
    chk("frame1_count", ld_re.size(), 8);

    // Overflow corner
    do_reset();
    clear_logs();
    for (int i = 0; i < 2 * D; i++)
      step(1'b1, 1'b0, (i == 0) ? 32767 : ((i == D) ? 1 : 0), 0);
    flushes(4);
`ifdef FFT_STAGE_SCALE_EN
    q_re = '{16383};
    check_log("ovf_sum", 0, q_re, '{0});
    check_log("ovf_diff", 4, '{16383}, '{1});
`else
    q_re = '{-32768};
    check_log("ovf_sum", 0, q_re, '{0});
    check_log("ovf_diff", 4, '{32766}, '{1});
`endif

    // Back-to-back frames
    do_reset();
    clear_logs();
    frame(1);
    frame(9);
    flushes(4);
`ifdef FFT_STAGE_SCALE_EN
    q_re = '{-2, -2, -2, -2, 10, 12, 12, 14};
`else
    q_re = '{-4, -4, -4, -4, 22, 24, 26, 28};
`endif
    q_d = '{1, 1, 1, 1, 0, 0, 0, 0};
    check_log("b2b", 4, q_re, q_d);

    // Idle gaps between every input
    do_reset();
    clear_logs();
    for (int i = 0; i < 2 * D; i++) begin
      step(1'b1, 1'b0, 1 + i, 0);
      step(1'b0, 1'b0, 0, 0);
      step(1'b0, 1'b0, 0, 0);
    end
    for (int i = 0; i < D; i++) begin
      step(1'b0, 1'b1, 0, 0);
      step(1'b0, 1'b0, 0, 0);
    end
`ifdef FFT_STAGE_SCALE_EN
    q_re = '{2, 4, 4, 6, -2, -2, -2, -2};
`else
    q_re = '{6, 8, 10, 12, -4, -4, -4, -4};
`endif
    q_d = '{0, 0, 0, 0, 1, 1, 1, 1};
    check_log("gaps", 0, q_re, q_d);

    // Reset in the middle of a frame (after the stage has primed)
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 100 + i, 0);
    do_reset();
    clear_logs();
    frame(21);
    chk("midrst_count", ld_re.size(), 4);
`ifdef FFT_STAGE_SCALE_EN
    q_re = '{22, 24, 24, 26};
`else
    q_re = '{46, 48, 50, 52};
`endif
    check_log("midrst", 0, q_re, '{0, 0, 0, 0});

    // Randomized traffic, complex data, random flush and gaps
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, ($urandom % 4) == 0,
           int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
      if (i == 300) do_reset();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
